urv_sim_mem_ctrl: RTL and testbench

- Synthesisable, parametrised dual-port memory subsystem for uRV CPU simulation and FPGA bring-up.
- Serves the `urv_cpu` instruction fetch port and data load/store port from one shared word array.
- Adds programmable pseudo-random fetch stalls, configurable load latency, a memory-mapped console TX FIFO with back-pressure, and a host preload port.
- Instantiated beside `urv_cpu` in system tops and benches.

---
 rtl/urv_sim_pkg.sv | 20 ++
 rtl/urv_sim_fifo.sv | 57 +++++
 rtl/urv_sim_mem_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_urv_sim_mem_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_sim_pkg.sv
// Shared definitions for the uRV simulation memory subsystem.
//   dm_state_t     : data-port controller states
//   LFSR_TAPS      : Galois tap mask for x^16+x^14+x^13+x^11
//   word_idx_w()   : word-index width for a given array depth
package urv_sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_CON_WAIT  = 2'd2
  } dm_state_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11 (maximal length).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int word_idx_w(input int mem_words);
    return $clog2(mem_words);
  endfunction

endpackage

// File: rtl/urv_sim_fifo.sv
// Synchronous ring-buffer FIFO with an extra pointer wrap bit.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset (flushes pointers)
//   push_i, data_i : write request and data (accepted when not full, or
//                    when full and a pop happens in the same cycle)
//   pop_i          : pop request, ignored when empty
//   data_o         : head entry (zero when empty)
//   full_o, empty_o: occupancy flags
//   free_o         : number of free entries
module urv_sim_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] free_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, used;
  logic             push_en, pop_en;

  assign used    = wr_ptr - rd_ptr;
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign free_o  = DEPTH_V - used;

  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  // Stale storage is masked so the head reads zero after reset.
  assign data_o  = empty_o ? '0 : store_q[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) store_q[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/urv_sim_mem_ctrl.sv
// Dual-port memory subsystem for uRV simulation / FPGA bring-up.
// One shared word array serves the instruction fetch port (with LFSR-driven
// pseudo-random stalls) and the data load/store port (with configurable load
// latency). A store to CONSOLE_ADDR goes to a TX FIFO instead of the RAM; a
// load from it returns the FIFO free-slot count. A host port preloads words.
// Ports:
//   clk_i, rst_n_i              : clock, asynchronous active-low reset
//   im_addr_i / im_data_o,
//   im_valid_o                  : fetch address, 1-cycle-latency word + valid
//   dm_addr_i, dm_data_s_i,
//   dm_data_select_i            : data address, store data, store byte lanes
//   dm_store_i, dm_load_i       : requests, sampled when dm_ready_o is high
//   dm_data_l_o, dm_load_done_o,
//   dm_store_done_o, dm_ready_o : load data, completion pulses, accept flag
//   host_we_i, host_addr_i,
//   host_data_i                 : full-word preload write (highest priority)
//   con_data_o, con_valid_o,
//   con_ready_i                 : console FIFO head / non-empty / pop
//   con_overflow_o              : saturating count of full-FIFO stall cycles
//   err_o                       : sticky simultaneous load+store flag
module urv_sim_mem_ctrl
  import urv_sim_pkg::*;
#(
  parameter int          MEM_WORDS      = 16384,
  parameter int          LOAD_LATENCY   = 1,
  parameter int          IM_STALL_THR   = 0,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter logic [31:0] CONSOLE_ADDR   = 32'h0010_0000,
  parameter int          CON_FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_ready_o,
  input  logic        host_we_i,
  input  logic [31:0] host_addr_i,
  input  logic [31:0] host_data_i,
  output logic [7:0]  con_data_o,
  output logic        con_valid_o,
  input  logic        con_ready_i,
  output logic [15:0] con_overflow_o,
  output logic        err_o
);

  localparam int         IW        = word_idx_w(MEM_WORDS);
  localparam int         CW        = $clog2(CON_FIFO_DEPTH) + 1;
  localparam logic [8:0] STALL_THR = 9'(IM_STALL_THR);
  localparam logic [3:0] LAT_M1    = 4'(LOAD_LATENCY - 1);
  localparam bit         LAT1      = (LOAD_LATENCY == 1);

  logic [31:0]   mem [MEM_WORDS];
  logic [IW-1:0] im_idx, dm_idx, host_idx;
  logic          unused_addr_bits;

  assign im_idx   = im_addr_i[IW+1:2];
  assign dm_idx   = dm_addr_i[IW+1:2];
  assign host_idx = host_addr_i[IW+1:2];
  assign unused_addr_bits = ^{im_addr_i[31:IW+2], im_addr_i[1:0],
                              host_addr_i[31:IW+2], host_addr_i[1:0]};

  // ---------------------------------------------------------------------
  // Fetch stage: LFSR gate, one-cycle registered read
  // ---------------------------------------------------------------------
  logic [15:0] lfsr;
  logic        fetch_en;

  assign fetch_en = ({1'b0, lfsr[7:0]} >= STALL_THR);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr <= LFSR_SEED;
    else          lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      im_valid_o <= 1'b0;
      im_data_o  <= '0;
    end else begin
      im_valid_o <= fetch_en;
      if (fetch_en) im_data_o <= mem[im_idx];
    end
  end

  // ---------------------------------------------------------------------
  // Data port request decode
  // ---------------------------------------------------------------------
  dm_state_t     state, state_nxt;
  logic          dm_accept, is_con, st_acc, ld_acc, store_ram, con_st;
  logic          fifo_full, fifo_empty, fifo_push, con_pop, slot_free;
  logic [7:0]    fifo_wdata;
  logic [CW-1:0] fifo_free;
  logic [31:0]   free_word;
  logic [3:0]    ld_cnt;
  logic          ld_fin, store_done_nxt, load_done_nxt;
  logic [IW-1:0] ld_idx;
  logic          ld_con;
  logic [7:0]    con_byte;

  // Host writes take the array port, so the data port is held off then.
  assign dm_accept  = (state == ST_IDLE) && !host_we_i;
  assign dm_ready_o = dm_accept;

  assign is_con    = (dm_addr_i == CONSOLE_ADDR);
  assign st_acc    = dm_accept && dm_store_i;
  assign ld_acc    = dm_accept && dm_load_i && !dm_store_i;
  assign store_ram = st_acc && !is_con;
  assign con_st    = st_acc && is_con;

  assign con_pop   = con_ready_i && !fifo_empty;
  assign slot_free = !fifo_full || con_pop;
  assign free_word = 32'(fifo_free);

  // The counter starts at LOAD_LATENCY-1 and the final decrement (1 -> 0)
  // is the completion edge.
  assign ld_fin    = (state == ST_LOAD_WAIT) && (ld_cnt == 4'd1);

  // ---------------------------------------------------------------------
  // Data FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (con_st && fifo_full)  state_nxt = ST_CON_WAIT;
        else if (ld_acc && !LAT1) state_nxt = ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: if (ld_fin)    state_nxt = ST_IDLE;
      ST_CON_WAIT:  if (slot_free) state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_push      = 1'b0;
    fifo_wdata     = dm_data_s_i[7:0];
    store_done_nxt = 1'b0;
    load_done_nxt  = ld_fin || (ld_acc && LAT1);
    case (state)
      ST_IDLE: begin
        fifo_push      = con_st && !fifo_full;
        store_done_nxt = store_ram || (con_st && !fifo_full);
      end
      ST_CON_WAIT: begin
        fifo_push      = slot_free;
        fifo_wdata     = con_byte;
        store_done_nxt = slot_free;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Completion / status registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ld_cnt          <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_data_l_o     <= '0;
      err_o           <= 1'b0;
      con_overflow_o  <= '0;
    end else begin
      dm_load_done_o  <= load_done_nxt;
      dm_store_done_o <= store_done_nxt;
      if (ld_acc)                      ld_cnt <= LAT_M1;
      else if (state == ST_LOAD_WAIT)  ld_cnt <= ld_cnt - 4'd1;
      // Memory is sampled at completion so earlier writes are visible.
      if (ld_acc && LAT1)  dm_data_l_o <= is_con ? free_word : mem[dm_idx];
      else if (ld_fin)     dm_data_l_o <= ld_con ? free_word : mem[ld_idx];
      if (dm_accept && dm_load_i && dm_store_i) err_o <= 1'b1;
      if (state == ST_CON_WAIT && !slot_free && con_overflow_o != 16'hFFFF)
        con_overflow_o <= con_overflow_o + 16'd1;
    end
  end

  // Request payload latches; only read in the state that loaded them.
  always_ff @(posedge clk_i) begin
    if (ld_acc) begin
      ld_idx <= dm_idx;
      ld_con <= is_con;
    end
    if (con_st) con_byte <= dm_data_s_i[7:0];
  end

  // ---------------------------------------------------------------------
  // Word array write port (host has priority)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (host_we_i) begin
      mem[host_idx] <= host_data_i;
    end else if (store_ram) begin
      for (int b = 0; b < 4; b++)
        if (dm_data_select_i[b]) mem[dm_idx][8*b +: 8] <= dm_data_s_i[8*b +: 8];
    end
  end

  // ---------------------------------------------------------------------
  // Console TX FIFO
  // ---------------------------------------------------------------------
  urv_sim_fifo #(
    .WIDTH (8),
    .DEPTH (CON_FIFO_DEPTH)
  ) u_con_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (con_ready_i),
    .data_o  (con_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .free_o  (fifo_free)
  );

  assign con_valid_o = !fifo_empty;

endmodule

// File: tb/tb_urv_sim_mem_ctrl.sv
// Bench for urv_sim_mem_ctrl. Instance A: 1-cycle loads, no fetch stalls,
// 2-entry console FIFO. Instance B: 4-cycle loads, IM_STALL_THR=128.
// Both share clock, reset, addresses, store data and the host port.
module tb_urv_sim_mem_ctrl;

  localparam logic [31:0] CON = 32'h0010_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] im_addr, dm_addr, dm_data_s, host_addr, host_data;
  logic [3:0]  dm_sel;
  logic        host_we, con_ready, st_a, ld_a, st_b, ld_b;

  logic [31:0] im_data_a, dl_a, im_data_b, dl_b;
  logic        im_valid_a, ldone_a, sdone_a, rdy_a, con_valid_a, err_a;
  logic        im_valid_b, ldone_b, sdone_b, rdy_b, con_valid_b, err_b;
  logic [7:0]  con_data_a, con_data_b;
  logic [15:0] ovf_a, ovf_b;

  urv_sim_mem_ctrl #(
    .MEM_WORDS(256), .LOAD_LATENCY(1), .IM_STALL_THR(0), .CON_FIFO_DEPTH(2)
  ) dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .im_addr_i(im_addr), .im_data_o(im_data_a), .im_valid_o(im_valid_a),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_store_i(st_a), .dm_load_i(ld_a), .dm_data_l_o(dl_a),
    .dm_load_done_o(ldone_a), .dm_store_done_o(sdone_a), .dm_ready_o(rdy_a),
    .host_we_i(host_we), .host_addr_i(host_addr), .host_data_i(host_data),
    .con_data_o(con_data_a), .con_valid_o(con_valid_a), .con_ready_i(con_ready),
    .con_overflow_o(ovf_a), .err_o(err_a)
  );

  urv_sim_mem_ctrl #(
    .MEM_WORDS(256), .LOAD_LATENCY(4), .IM_STALL_THR(128), .CON_FIFO_DEPTH(16)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .im_addr_i(im_addr), .im_data_o(im_data_b), .im_valid_o(im_valid_b),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_store_i(st_b), .dm_load_i(ld_b), .dm_data_l_o(dl_b),
    .dm_load_done_o(ldone_b), .dm_store_done_o(sdone_b), .dm_ready_o(rdy_b),
    .host_we_i(host_we), .host_addr_i(host_addr), .host_data_i(host_data),
    .con_data_o(con_data_b), .con_valid_o(con_valid_b), .con_ready_i(con_ready),
    .con_overflow_o(ovf_b), .err_o(err_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [31:0] fpat(input int i);
    return (32'h0101_0101 * i) ^ 32'hA5A5_A5A5;
  endfunction

  // Scoreboard for instance A load data.
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && ldone_a) begin
      if (exp_q.size() == 0) chk("unexpected_load_done_a", 32'd1, 32'd0);
      else                   chk("load_data_a", dl_a, exp_q.pop_front());
    end
  end

  typedef struct {
    bit          is_ld;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[10];

  task automatic host_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_data = d;
    #1 chk("host_blocks_ready_a", {31'd0, rdy_a}, 32'd0);
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic a_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    dm_addr = a; dm_data_s = d; dm_sel = s; st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    chk("store_done_a", {31'd0, sdone_a}, 32'd1);
  endtask

  task automatic a_load(input logic [31:0] a, input logic [31:0] e);
    @(negedge clk);
    dm_addr = a; ld_a = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    ld_a = 1'b0;
    chk("load_latency_a", {31'd0, ldone_a}, 32'd1);
  endtask

  task automatic check_reset();
    chk("rst_im_valid_a", {31'd0, im_valid_a}, 32'd0);
    chk("rst_im_data_a", im_data_a, 32'd0);
    chk("rst_load_data_a", dl_a, 32'd0);
    chk("rst_done_a", {30'd0, ldone_a, sdone_a}, 32'd0);
    chk("rst_ready_a", {31'd0, rdy_a}, 32'd1);
    chk("rst_con_valid_a", {31'd0, con_valid_a}, 32'd0);
    chk("rst_con_data_a", {24'd0, con_data_a}, 32'd0);
    chk("rst_overflow_a", {16'd0, ovf_a}, 32'd0);
    chk("rst_err_a", {31'd0, err_a}, 32'd0);
    chk("rst_im_valid_b", {31'd0, im_valid_b}, 32'd0);
    chk("rst_im_data_b", im_data_b, 32'd0);
    chk("rst_load_data_b", dl_b, 32'd0);
    chk("rst_done_b", {30'd0, ldone_b, sdone_b}, 32'd0);
    chk("rst_ready_b", {31'd0, rdy_b}, 32'd1);
    chk("rst_err_b", {31'd0, err_b}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          valid_b, bad_a_v, bad_a_d, bad_b_d, bad_b_hold, cur;
    logic [31:0] last_b;

    vt[0] = '{1'b1, 32'h0000_0014, 32'h0,          4'h0, 32'hDEAD_BEEF};
    vt[1] = '{1'b0, 32'h0000_0020, 32'h1122_3344,  4'b0101, 32'h0};
    vt[2] = '{1'b1, 32'h0000_0020, 32'h0,          4'h0, 32'hFF22_FF44};
    vt[3] = '{1'b1, 32'h0000_0420, 32'h0,          4'h0, 32'hFF22_FF44};
    vt[4] = '{1'b1, 32'h0000_0023, 32'h0,          4'h0, 32'hFF22_FF44};
    vt[5] = '{1'b0, 32'h0000_0040, 32'hCAFE_F00D,  4'hF, 32'h0};
    vt[6] = '{1'b0, 32'h0000_0040, 32'h0000_00AA,  4'b1000, 32'h0};
    vt[7] = '{1'b1, 32'h0000_0040, 32'h0,          4'h0, 32'h00FE_F00D};
    vt[8] = '{1'b1, 32'hFFFF_FC40, 32'h0,          4'h0, 32'h00FE_F00D};
    vt[9] = '{1'b1, CON,           32'h0,          4'h0, 32'h0000_0002};

    rst_n = 1'b0; im_addr = '0; dm_addr = '0; dm_data_s = '0; dm_sel = '0;
    host_addr = '0; host_data = '0; host_we = 1'b0; con_ready = 1'b0;
    st_a = 1'b0; ld_a = 1'b0; st_b = 1'b0; ld_b = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    // Preload
    host_wr(32'h0000_0014, 32'hDEAD_BEEF);
    host_wr(32'h0000_0020, 32'hFFFF_FFFF);
    host_wr(32'h0000_0000, 32'h1212_1212);
    for (int i = 0; i < 8; i++) host_wr((32 + i) * 4, fpat(i));

    // Table-driven loads/stores on A
    for (int i = 0; i < 10; i++) begin
      if (vt[i].is_ld) a_load(vt[i].addr, vt[i].exp);
      else             a_store(vt[i].addr, vt[i].data, vt[i].sel);
    end

    // Console FIFO back-pressure on A (depth 2)
    a_store(CON, 32'h0000_0041, 4'hF);
    chk("con_valid_after_push", {31'd0, con_valid_a}, 32'd1);
    chk("con_head_A", {24'd0, con_data_a}, 32'h41);
    a_store(CON, 32'h0000_0042, 4'hF);
    a_load(CON, 32'd0);
    @(negedge clk);
    dm_addr = CON; dm_data_s = 32'h0000_0043; dm_sel = 4'hF; st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0; dm_data_s = 32'h0000_0099;
    chk("con_full_no_done", {31'd0, sdone_a}, 32'd0);
    chk("con_wait_not_ready", {31'd0, rdy_a}, 32'd0);
    chk("con_overflow_start", {16'd0, ovf_a}, 32'd0);
    repeat (3) @(negedge clk);
    chk("con_overflow_3", {16'd0, ovf_a}, 32'd3);
    chk("con_wait_still_no_done", {31'd0, sdone_a}, 32'd0);
    chk("con_head_before_pop", {24'd0, con_data_a}, 32'h41);
    con_ready = 1'b1;
    @(negedge clk);
    chk("con_third_done", {31'd0, sdone_a}, 32'd1);
    chk("con_overflow_held", {16'd0, ovf_a}, 32'd3);
    chk("con_head_B", {24'd0, con_data_a}, 32'h42);
    @(negedge clk);
    chk("con_head_C", {24'd0, con_data_a}, 32'h43);
    chk("con_done_single_pulse", {31'd0, sdone_a}, 32'd0);
    @(negedge clk);
    chk("con_drained", {31'd0, con_valid_a}, 32'd0);
    @(negedge clk);
    con_ready = 1'b0;
    a_load(CON, 32'd2);
    a_load(32'h0000_0000, 32'h1212_1212);

    // Simultaneous load+store on A
    @(negedge clk);
    dm_addr = 32'h0000_0060; dm_data_s = 32'h1234_5678; dm_sel = 4'hF;
    st_a = 1'b1; ld_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0; ld_a = 1'b0;
    chk("both_store_done", {31'd0, sdone_a}, 32'd1);
    chk("both_no_load_done", {31'd0, ldone_a}, 32'd0);
    chk("both_err", {31'd0, err_a}, 32'd1);
    a_load(32'h0000_0060, 32'h1234_5678);

    // Fetch path: A never stalls, B stalls about half the time
    valid_b = 0; bad_a_v = 0; bad_a_d = 0; bad_b_d = 0; bad_b_hold = 0;
    @(negedge clk);
    cur = 0; im_addr = 32 * 4; last_b = im_data_b;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (!im_valid_a) bad_a_v++;
      else if (im_data_a !== fpat(cur)) bad_a_d++;
      if (im_valid_b) begin
        valid_b++;
        if (im_data_b !== fpat(cur)) bad_b_d++;
      end else if (im_data_b !== last_b) bad_b_hold++;
      last_b = im_data_b;
      cur = $urandom_range(0, 7);
      im_addr = (32 + cur) * 4;
    end
    chk("fetch_a_always_valid", bad_a_v, 32'd0);
    chk("fetch_a_data", bad_a_d, 32'd0);
    chk("fetch_b_data", bad_b_d, 32'd0);
    chk("fetch_b_hold", bad_b_hold, 32'd0);
    n_chk++;
    if (valid_b >= 4500 && valid_b <= 5500) n_pass++;
    else $display("FAIL stall_ratio_b: valid %0d of 10000, required 4500..5500", valid_b);

    // B: 4-cycle load; a host write during the wait is visible at completion
    @(negedge clk);
    dm_addr = 32'h0000_0014; ld_b = 1'b1;
    @(negedge clk);
    ld_b = 1'b0;
    chk("lat4_t1_ready", {31'd0, rdy_b}, 32'd0);
    chk("lat4_t1_done", {31'd0, ldone_b}, 32'd0);
    @(negedge clk);
    chk("lat4_t2_ready", {31'd0, rdy_b}, 32'd0);
    chk("lat4_t2_done", {31'd0, ldone_b}, 32'd0);
    host_we = 1'b1; host_addr = 32'h0000_0014; host_data = 32'h55AA_55AA;
    @(negedge clk);
    host_we = 1'b0;
    chk("lat4_t3_ready", {31'd0, rdy_b}, 32'd0);
    chk("lat4_t3_done", {31'd0, ldone_b}, 32'd0);
    @(negedge clk);
    chk("lat4_t4_done", {31'd0, ldone_b}, 32'd1);
    chk("lat4_t4_data", dl_b, 32'h55AA_55AA);
    chk("lat4_t4_ready", {31'd0, rdy_b}, 32'd1);
    @(negedge clk);
    chk("lat4_single_pulse", {31'd0, ldone_b}, 32'd0);

    // B: store then load sees the stored word
    @(negedge clk);
    dm_addr = 32'h0000_0080; dm_data_s = 32'h0BAD_CAFE; dm_sel = 4'hF; st_b = 1'b1;
    @(negedge clk);
    st_b = 1'b0; ld_b = 1'b1;
    chk("store_done_b", {31'd0, sdone_b}, 32'd1);
    @(negedge clk);
    ld_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("load_after_store_b_done", {31'd0, ldone_b}, 32'd1);
    chk("load_after_store_b_data", dl_b, 32'h0BAD_CAFE);

    // Reset in the middle of a B load wait, with a byte queued in A's FIFO
    a_store(CON, 32'h0000_0058, 4'hF);
    @(negedge clk);
    dm_addr = 32'h0000_0080; ld_b = 1'b1;
    @(negedge clk);
    ld_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_done_after_reset_b", {30'd0, ldone_b, sdone_b}, 32'd0);
    end

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
